// File: rtl/writeback_stage_if.sv
// Writeback stage bus: in-order pipeline result, long-latency handshake, hazard status.
interface writeback_stage_if #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
);
  logic                      pipe_valid;
  logic [REG_ADDR_WIDTH-1:0] pipe_rd;
  logic                      pipe_is_load;
  logic [2:0]                pipe_funct3;
  logic [1:0]                pipe_byte_off;
  logic [XLEN-1:0]           pipe_result;
  logic [XLEN-1:0]           pipe_load_data;

  logic                      lu_valid;
  logic                      lu_ready;
  logic [REG_ADDR_WIDTH-1:0] lu_rd;
  logic [XLEN-1:0]           lu_result;

  logic                      stall_req;
  logic                      pend_valid;
  logic [REG_ADDR_WIDTH-1:0] pend_rd;

  // Upstream side: pipeline and long-latency unit drive results, observe status.
  modport master (
    output pipe_valid, pipe_rd, pipe_is_load, pipe_funct3, pipe_byte_off,
           pipe_result, pipe_load_data, lu_valid, lu_rd, lu_result,
    input  lu_ready, stall_req, pend_valid, pend_rd
  );

  // Writeback side.
  modport slave (
    input  pipe_valid, pipe_rd, pipe_is_load, pipe_funct3, pipe_byte_off,
           pipe_result, pipe_load_data, lu_valid, lu_rd, lu_result,
    output lu_ready, stall_req, pend_valid, pend_rd
  );
endinterface

// File: rtl/writeback_stage.sv
// Final integer pipeline stage: merges in-order and long-latency results into
// the register file write port, extracts RV32 load data, buffers one
// long-latency result with an anti-starvation stall.
// Optional feature macro: WB_MISALIGN_CHECK_EN (suppress misaligned LH/LHU/LW
// writes and pulse misalign_err).
module writeback_stage #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned STARVE_LIMIT   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  writeback_stage_if.slave          wb,
  output logic                      rf_we,
  output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
  output logic [XLEN-1:0]           rf_wdata,
  output logic                      misalign_err
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_PEND  = 1'b1
  } state_t;

  state_t                    state_q, state_d;
  logic [REG_ADDR_WIDTH-1:0] pend_rd_q, pend_rd_d;
  logic [XLEN-1:0]           pend_data_q, pend_data_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      rf_we_d;
  logic [REG_ADDR_WIDTH-1:0] rf_waddr_d;
  logic [XLEN-1:0]           rf_wdata_d;

  logic                      lu_ready_c;
  logic                      stall_c;
  logic                      lu_acc_c;
  logic                      pipe_wr_c;
  logic                      misalign_c;
  logic [XLEN-1:0]           pipe_data_c;

  // RV32 load extraction from the aligned memory word.
  function automatic logic [XLEN-1:0] extract_load(input logic [2:0]      funct3,
                                                   input logic [1:0]      off,
                                                   input logic [XLEN-1:0] word);
    logic [7:0]      b;
    logic [15:0]     h;
    logic [XLEN-1:0] res;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (funct3)
      3'b000:  res = {{(XLEN-8){b[7]}}, b};
      3'b001:  res = {{(XLEN-16){h[15]}}, h};
      3'b010:  res = word;
      3'b100:  res = {{(XLEN-8){1'b0}}, b};
      3'b101:  res = {{(XLEN-16){1'b0}}, h};
      default: res = '0;
    endcase
    return res;
  endfunction

  // Status is derived from state only; no path from lu_valid to lu_ready.
  assign lu_ready_c    = (state_q == ST_EMPTY);
  assign stall_c       = (state_q == ST_PEND) && (cnt_q == CNT_W'(STARVE_LIMIT));
  assign wb.lu_ready   = lu_ready_c;
  assign wb.stall_req  = stall_c;
  assign wb.pend_valid = (state_q == ST_PEND);
  assign wb.pend_rd    = pend_rd_q;

  assign lu_acc_c    = wb.lu_valid && lu_ready_c;
  assign pipe_wr_c   = wb.pipe_valid && (wb.pipe_rd != '0);
  assign pipe_data_c = wb.pipe_is_load
                     ? extract_load(wb.pipe_funct3, wb.pipe_byte_off, wb.pipe_load_data)
                     : wb.pipe_result;

`ifdef WB_MISALIGN_CHECK_EN
  // Halfword loads at odd offsets and word loads at any nonzero offset.
  assign misalign_c = wb.pipe_is_load &&
                      ((((wb.pipe_funct3 == 3'b001) || (wb.pipe_funct3 == 3'b101)) &&
                        wb.pipe_byte_off[0]) ||
                       ((wb.pipe_funct3 == 3'b010) && (wb.pipe_byte_off != 2'b00)));
`else
  assign misalign_c = 1'b0;
`endif

  // Source selection, pending buffer and starve counter next-state.
  always_comb begin
    state_d     = state_q;
    pend_rd_d   = pend_rd_q;
    pend_data_d = pend_data_q;
    cnt_d       = cnt_q;
    rf_we_d     = 1'b0;
    rf_waddr_d  = rf_waddr;
    rf_wdata_d  = rf_wdata;

    if (stall_c) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = pend_rd_q;
      rf_wdata_d = pend_data_q;
      state_d    = ST_EMPTY;
      cnt_d      = '0;
    end else if (pipe_wr_c) begin
      if (!misalign_c) begin
        rf_we_d    = 1'b1;
        rf_waddr_d = wb.pipe_rd;
        rf_wdata_d = pipe_data_c;
      end
      if (state_q == ST_PEND) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else if (lu_acc_c && (wb.lu_rd != '0)) begin
        state_d     = ST_PEND;
        pend_rd_d   = wb.lu_rd;
        pend_data_d = wb.lu_result;
        cnt_d       = '0;
      end
    end else if (state_q == ST_PEND) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = pend_rd_q;
      rf_wdata_d = pend_data_q;
      state_d    = ST_EMPTY;
      cnt_d      = '0;
    end else if (lu_acc_c && (wb.lu_rd != '0)) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = wb.lu_rd;
      rf_wdata_d = wb.lu_result;
    end
  end

  // State and registered write-port outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      pend_rd_q   <= '0;
      pend_data_q <= '0;
      cnt_q       <= '0;
      rf_we       <= 1'b0;
      rf_waddr    <= '0;
      rf_wdata    <= '0;
    end else begin
      state_q     <= state_d;
      pend_rd_q   <= pend_rd_d;
      pend_data_q <= pend_data_d;
      cnt_q       <= cnt_d;
      rf_we       <= rf_we_d;
      rf_waddr    <= rf_waddr_d;
      rf_wdata    <= rf_wdata_d;
    end
  end

`ifdef WB_MISALIGN_CHECK_EN
  // Error pulse lands in the cycle the suppressed write would have appeared.
  always_ff @(posedge clk) begin
    if (reset) begin
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= pipe_wr_c && !stall_c && misalign_c;
    end
  end
`else
  assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage with an expected-write scoreboard.
module tb_writeback_stage;

  logic        clk;
  logic        reset;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        misalign_err;

  int checks;
  int failures;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [4:0]  last_addr;
  logic [31:0] last_data;

  writeback_stage_if #(.XLEN(32), .REG_ADDR_WIDTH(5)) wb_bus ();

  writeback_stage #(.XLEN(32), .REG_ADDR_WIDTH(5), .STARVE_LIMIT(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .wb           (wb_bus.slave),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .misalign_err (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic we, input logic [4:0] addr, input logic [31:0] data);
    exp_t e;
    e.we = we;
    e.addr = addr;
    e.data = data;
    sb.push_back(e);
  endtask

  // Advance one cycle and compare the write port against the oldest expectation.
  task automatic cyc(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_we"}, 32'(rf_we), 32'(e.we));
      if (e.we) begin
        last_addr = e.addr;
        last_data = e.data;
      end
      chk({tag, "_waddr"}, 32'(rf_waddr), 32'(last_addr));
      chk({tag, "_wdata"}, rf_wdata, last_data);
    end
  endtask

  task automatic set_pipe(input logic v, input logic [4:0] rd, input logic ld,
                          input logic [2:0] f3, input logic [1:0] off,
                          input logic [31:0] res, input logic [31:0] ldata);
    wb_bus.pipe_valid     = v;
    wb_bus.pipe_rd        = rd;
    wb_bus.pipe_is_load   = ld;
    wb_bus.pipe_funct3    = f3;
    wb_bus.pipe_byte_off  = off;
    wb_bus.pipe_result    = res;
    wb_bus.pipe_load_data = ldata;
  endtask

  task automatic set_lu(input logic v, input logic [4:0] rd, input logic [31:0] res);
    wb_bus.lu_valid  = v;
    wb_bus.lu_rd     = rd;
    wb_bus.lu_result = res;
  endtask

  task automatic load(input string tag, input logic [2:0] f3, input logic [1:0] off,
                      input logic [31:0] exp);
    set_pipe(1'b1, 5'd4, 1'b1, f3, off, 32'hDEAD_BEEF, 32'h80FF_7F01);
    push(1'b1, 5'd4, exp);
    cyc(tag);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    last_addr = '0;
    last_data = '0;
    reset = 1'b1;
    set_pipe(1'b0, 5'd0, 1'b0, 3'b000, 2'b00, 32'h0, 32'h0);
    set_lu(1'b0, 5'd0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", 32'(rf_we), 32'd0);
    chk("rst_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    chk("rst_pend_valid", 32'(wb_bus.pend_valid), 32'd0);
    chk("rst_pend_rd", 32'(wb_bus.pend_rd), 32'd0);
    chk("rst_lu_ready", 32'(wb_bus.lu_ready), 32'd1);
    chk("rst_stall", 32'(wb_bus.stall_req), 32'd0);
    chk("rst_misalign", 32'(misalign_err), 32'd0);
    reset = 1'b0;

    // Plain ALU result.
    set_pipe(1'b1, 5'd5, 1'b0, 3'b000, 2'b00, 32'h1234_5678, 32'h0);
    push(1'b1, 5'd5, 32'h1234_5678);
    cyc("alu_rd5");

    // One-cycle reset clears the write port.
    reset = 1'b1;
    set_pipe(1'b0, 5'd0, 1'b0, 3'b000, 2'b00, 32'h0, 32'h0);
    last_addr = '0;
    last_data = '0;
    push(1'b0, 5'd0, 32'h0);
    cyc("hold_rst");
    reset = 1'b0;

    // Load extraction on 0x80FF_7F01.
    load("lb_off0",  3'b000, 2'd0, 32'h0000_0001);
    load("lb_off2",  3'b000, 2'd2, 32'hFFFF_FFFF);
    load("lbu_off3", 3'b100, 2'd3, 32'h0000_0080);
    load("lh_off2",  3'b001, 2'd2, 32'hFFFF_80FF);
    load("lhu_off0", 3'b101, 2'd0, 32'h0000_7F01);
    load("lhu_off2", 3'b101, 2'd2, 32'h0000_80FF);
    load("lw_off0",  3'b010, 2'd0, 32'h80FF_7F01);
    load("bad_f3",   3'b011, 2'd0, 32'h0000_0000);

    set_pipe(1'b0, 5'd0, 1'b0, 3'b000, 2'b00, 32'h0, 32'h0);
    push(1'b0, 5'd0, 32'h0);
    cyc("idle");

    // Long-latency result with an idle pipe bypasses the buffer.
    chk("lu_ready_idle", 32'(wb_bus.lu_ready), 32'd1);
    set_lu(1'b1, 5'd7, 32'h0000_00AA);
    push(1'b1, 5'd7, 32'h0000_00AA);
    cyc("lu_direct");
    set_lu(1'b0, 5'd0, 32'h0);
    chk("lu_direct_pend", 32'(wb_bus.pend_valid), 32'd0);

    // Collision: pipe wins, lu result buffered.
    set_pipe(1'b1, 5'd3, 1'b0, 3'b000, 2'b00, 32'h0000_0033, 32'h0);
    set_lu(1'b1, 5'd7, 32'h0000_00BB);
    push(1'b1, 5'd3, 32'h0000_0033);
    cyc("coll_pipe");
    set_lu(1'b0, 5'd0, 32'h0);
    set_pipe(1'b0, 5'd0, 1'b0, 3'b000, 2'b00, 32'h0, 32'h0);
    chk("coll_pend_valid", 32'(wb_bus.pend_valid), 32'd1);
    chk("coll_pend_rd", 32'(wb_bus.pend_rd), 32'd7);
    chk("coll_lu_ready", 32'(wb_bus.lu_ready), 32'd0);
    push(1'b1, 5'd7, 32'h0000_00BB);
    cyc("coll_drain");
    chk("coll_pend_clear", 32'(wb_bus.pend_valid), 32'd0);
    chk("coll_lu_ready2", 32'(wb_bus.lu_ready), 32'd1);

    // Starvation: pending rd9 blocked by a continuous pipe stream.
    set_pipe(1'b1, 5'd1, 1'b0, 3'b000, 2'b00, 32'h0000_0011, 32'h0);
    set_lu(1'b1, 5'd9, 32'h0000_0099);
    push(1'b1, 5'd1, 32'h0000_0011);
    cyc("starve_setup");
    set_lu(1'b0, 5'd0, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("starve_nostall%0d", i), 32'(wb_bus.stall_req), 32'd0);
      set_pipe(1'b1, 5'd1, 1'b0, 3'b000, 2'b00, 32'h0000_0100 + 32'(i), 32'h0);
      push(1'b1, 5'd1, 32'h0000_0100 + 32'(i));
      cyc($sformatf("starve_blk%0d", i));
    end
    chk("starve_stall", 32'(wb_bus.stall_req), 32'd1);
    set_pipe(1'b1, 5'd1, 1'b0, 3'b000, 2'b00, 32'h0000_0EEE, 32'h0);
    push(1'b1, 5'd9, 32'h0000_0099);
    cyc("starve_drain");
    chk("starve_stall_off", 32'(wb_bus.stall_req), 32'd0);
    chk("starve_pend_clear", 32'(wb_bus.pend_valid), 32'd0);
    chk("starve_lu_ready", 32'(wb_bus.lu_ready), 32'd1);
    set_pipe(1'b1, 5'd1, 1'b0, 3'b000, 2'b00, 32'h0000_0222, 32'h0);
    push(1'b1, 5'd1, 32'h0000_0222);
    cyc("starve_resume");

    // rd=0 from both sources: consumed, not written, not buffered.
    set_pipe(1'b1, 5'd0, 1'b0, 3'b000, 2'b00, 32'h0000_DEAD, 32'h0);
    set_lu(1'b1, 5'd0, 32'h0000_BEEF);
    push(1'b0, 5'd0, 32'h0);
    cyc("rd0_both");
    chk("rd0_pend", 32'(wb_bus.pend_valid), 32'd0);

    // Pipe rd=0 does not block a long-latency write.
    set_lu(1'b1, 5'd12, 32'h0000_000C);
    push(1'b1, 5'd12, 32'h0000_000C);
    cyc("rd0_pipe_lu");
    set_lu(1'b0, 5'd0, 32'h0);
    chk("rd0_pipe_lu_pend", 32'(wb_bus.pend_valid), 32'd0);

    // Misaligned word load.
    set_pipe(1'b1, 5'd6, 1'b1, 3'b010, 2'd1, 32'h0, 32'h80FF_7F01);
`ifdef WB_MISALIGN_CHECK_EN
    push(1'b0, 5'd0, 32'h0);
    cyc("lw_misalign");
    chk("misalign_pulse", 32'(misalign_err), 32'd1);
    set_pipe(1'b0, 5'd0, 1'b0, 3'b000, 2'b00, 32'h0, 32'h0);
    push(1'b0, 5'd0, 32'h0);
    cyc("misalign_after");
    chk("misalign_clear", 32'(misalign_err), 32'd0);
`else
    push(1'b1, 5'd6, 32'h80FF_7F01);
    cyc("lw_off1");
    chk("misalign_tied", 32'(misalign_err), 32'd0);
`endif

    // Reset while a result is pending discards it.
    set_pipe(1'b1, 5'd2, 1'b0, 3'b000, 2'b00, 32'h0000_0022, 32'h0);
    set_lu(1'b1, 5'd10, 32'h0000_00A0);
    push(1'b1, 5'd2, 32'h0000_0022);
    cyc("mid_setup");
    set_lu(1'b0, 5'd0, 32'h0);
    set_pipe(1'b0, 5'd0, 1'b0, 3'b000, 2'b00, 32'h0, 32'h0);
    chk("mid_pend_before", 32'(wb_bus.pend_valid), 32'd1);
    reset = 1'b1;
    last_addr = '0;
    last_data = '0;
    push(1'b0, 5'd0, 32'h0);
    cyc("mid_reset");
    reset = 1'b0;
    chk("mid_pend_after", 32'(wb_bus.pend_valid), 32'd0);
    push(1'b0, 5'd0, 32'h0);
    cyc("mid_no_write");

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage of the integer core, directly upstream of the register file write port; owns rf_we/rf_waddr/rf_wdata.
- Merges two result sources: the in-order pipeline (ALU result or load data from memory) and a long-latency unit (divider/multiplier) with a valid/ready handshake.
- Performs RV32 load extraction (byte/half/word, sign/zero extend). Buffers one long-latency result, with anti-starvation stall.

Parameters:
XLEN, 32, data width in bits
REG_ADDR_WIDTH, 5, register address width
STARVE_LIMIT, 4, cycles a buffered long-latency result may wait before forcing a pipeline stall (>=1)

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
pipe_valid  in  1  pipeline result present this cycle
pipe_rd  in  REG_ADDR_WIDTH  pipeline destination register
pipe_is_load  in  1  1: write extracted load data; 0: write pipe_result
pipe_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
pipe_byte_off  in  2  address[1:0] of the load
pipe_result  in  XLEN  ALU/CSR result
pipe_load_data  in  XLEN  raw aligned word from data memory
lu_valid  in  1  long-latency result offered
lu_ready  out  1  long-latency result accepted when lu_valid && lu_ready
lu_rd  in  REG_ADDR_WIDTH  long-latency destination
lu_result  in  XLEN  long-latency result
stall_req  out  1  upstream must not present pipe_valid this cycle
pend_valid  out  1  buffered long-latency result pending (hazard unit)
pend_rd  out  REG_ADDR_WIDTH  destination of pending result
rf_we  out  1  register file write enable (registered)
rf_waddr  out  REG_ADDR_WIDTH  register file write address (registered)
rf_wdata  out  XLEN  register file write data (registered)
misalign_err  out  1  misaligned load pulse (optional feature)

Behaviour:
- Reset: rf_we=0, rf_waddr=0, rf_wdata=0, pend_valid=0, pend_rd=0, starve counter=0, misalign_err=0. Reset mid-operation discards the pending result; no write issues in the following cycle.
- Latency: a source selected in cycle N appears on rf_* in cycle N+1 and is committed by the register file at the end of N+1.
- lu_ready = !pend_valid (state only, no combinational path from lu_valid).
- Priority per cycle, first match wins:
  1. stall_req=1: pending is written; pipe inputs are ignored (upstream contract).
  2. pipe_valid && pipe_rd!=0: the pipeline result is written. A long-latency result accepted this cycle goes to pending.
  3. pend_valid: pending is written and pend_valid clears.
  4. lu accepted && lu_rd!=0: written directly, bypassing pending.
  5. Otherwise rf_we=0 next cycle.
- pipe_valid with pipe_rd=0, or lu accepted with lu_rd=0: consumed, never written, never buffered.
- A pend_valid clear and a new lu acceptance never occur in the same cycle, because lu_ready=0 while pending.
- Starve counter:
  - Increments each cycle pend_valid=1 and pending is not written; clears when pending is written.
  - stall_req = pend_valid && (counter == STARVE_LIMIT).
- Load extraction, when pipe_is_load=1:
  - LB/LBU: byte pipe_byte_off, sign- or zero-extended.
  - LH/LHU: half pipe_byte_off[1], extended.
  - LW: full word; pipe_byte_off ignored.
  - Any other funct3: writes 0.
- rf_waddr/rf_wdata keep their last values when rf_we=0.

Optional Feature:
WB_MISALIGN_CHECK_EN
- Defined: a pipeline load with LH/LHU and byte_off[0]=1, or LW with byte_off!=0, suppresses the write (rf_we=0). misalign_err pulses high for one cycle, aligned with the cycle the write would have appeared.
- Undefined: misalign_err is tied 0. Misaligned loads are extracted using the rules above unchanged.

Test Plan:
- Reset, then pipe_valid with rd=5, is_load=0, result=0x1234_5678 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234_5678. Hold reset one cycle -> all outputs 0.
- Loads on load_data=0x80FF_7F01: LB off=0 -> 0x0000_0001; LB off=2 -> 0xFFFF_FFFF; LBU off=3 -> 0x0000_0080; LH off=2 -> 0xFFFF_80FF; LHU off=0 -> 0x0000_7F01.
- lu_valid, rd=7, result=0xAA, pipe idle -> lu_ready=1; next cycle rf_we=1, waddr=7, wdata=0xAA; pend_valid stays 0.
- lu rd=7 collides with pipe rd=3 -> rd3 written first, pend_valid=1, pend_rd=7, lu_ready=0. Pipe idle next cycle -> rd7 written, pend_valid=0.
- Pending rd=9 with pipe_valid continuous (rd=1): after STARVE_LIMIT=4 blocked cycles -> stall_req=1 for one cycle, rd9 written next cycle, counter=0, lu_ready=1 again.
- pipe rd=0 and lu rd=0 in the same cycle -> no write, pend_valid=0. With WB_MISALIGN_CHECK_EN: LW off=1 -> rf_we=0, misalign_err=1 for one cycle.
